// File: rtl/seq_div_pkg.sv
// Shared constants and state encoding for the sequential divider.
package seq_div_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OVFL = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift, trial subtract, select, quotient bit.
module div_step #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);

  logic [W:0] w_trial;
  logic       w_ge;

  // Partial remainder stays below the divisor, so a successful subtract fits W bits.
  always_comb begin
    w_trial = {i_rem, i_quo[W-1]};
    w_ge    = (w_trial >= {1'b0, i_divisor});
    o_rem   = w_ge ? W'(w_trial - {1'b0, i_divisor}) : w_trial[W-1:0];
    o_quo   = {i_quo[W-2:0], w_ge};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: 2W-bit dividend by W-bit divisor,
// one quotient bit per clock, with overflow detection before iterating.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 overflow,
  output logic                 ready
);

  localparam int unsigned    CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic              w_last;
  logic [WIDTH-1:0]  w_upper;

  logic [WIDTH-1:0]  r_rem;
  logic [WIDTH-1:0]  r_quo;
  logic [WIDTH-1:0]  r_div;
  logic [CW-1:0]     r_count;

  logic [WIDTH-1:0]  r_quotient;
  logic [WIDTH-1:0]  r_remainder;
  logic              r_overflow;

  logic [WIDTH-1:0]  w_step_rem;
  logic [WIDTH-1:0]  w_step_quo;

  assign w_upper   = dividend[2*WIDTH-1:WIDTH];
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign overflow  = r_overflow;

  div_step #(.W(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_div),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode, handshake and completion strobes.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    ready    = 1'b0;
    unique case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          // Upper half >= divisor also catches divisor == 0.
          w_next   = (w_upper >= divisor) ? OVFL : CALC;
        end
      end
      CALC: begin
        if (r_count == LAST) begin
          w_last = 1'b1;
          w_next = IDLE;
        end
      end
      OVFL:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Working registers and result registers; results only change on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rem   <= w_upper;
        r_quo   <= dividend[WIDTH-1:0];
        r_div   <= divisor;
        r_count <= '0;
      end
      if (r_state == CALC) begin
        r_rem   <= w_step_rem;
        r_quo   <= w_step_quo;
        r_count <= r_count + 1'b1;
        if (w_last) begin
          r_quotient  <= w_step_quo;
          r_remainder <= w_step_rem;
          r_overflow  <= 1'b0;
        end
      end
      if (r_state == OVFL) begin
        r_quotient  <= '1;
        r_remainder <= '0;
        r_overflow  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        overflow;
  logic        ready;

  int checks   = 0;
  int failures = 0;

  seq_divider #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .overflow  (overflow),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division with the overflow rule.
  task automatic model(input logic [31:0] dd, input logic [15:0] dv,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic ov, output int lat);
    longint unsigned qq;
    if (dv == 16'd0) begin
      q = 16'hFFFF; r = 16'd0; ov = 1'b1; lat = 1;
    end else begin
      qq = longint'(dd) / longint'(dv);
      if (qq > 64'h0000_FFFF) begin
        q = 16'hFFFF; r = 16'd0; ov = 1'b1; lat = 1;
      end else begin
        q = qq[15:0]; r = 16'(longint'(dd) % longint'(dv)); ov = 1'b0; lat = 16;
      end
    end
  endtask

  // Pulse start for one edge and count edges until ready returns (bounded).
  task automatic run_op(input logic [31:0] dd, input logic [15:0] dv, output int lat);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (!ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({ready, quotient, remainder, overflow} !== {1'b1, 16'd0, 16'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b q=%h r=%h ov=%b want rdy=1 q=0 r=0 ov=0",
               ready, quotient, remainder, overflow);
    end
  endtask

  task automatic test_directed(input string name, input logic [31:0] dd, input logic [15:0] dv,
                               input logic [15:0] eq, input logic [15:0] er, input logic eov,
                               input int elat);
    int lat;
    run_op(dd, dv, lat);
    checks++;
    if (lat !== elat) begin
      failures++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, elat);
    end
    checks++;
    if ({quotient, remainder, overflow} !== {eq, er, eov}) begin
      failures++;
      $display("FAIL %s_result got q=%h r=%h ov=%b want q=%h r=%h ov=%b",
               name, quotient, remainder, overflow, eq, er, eov);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    logic [15:0] pq, pr;
    logic        pov;
    pq = quotient; pr = remainder; pov = overflow;
    dividend = 32'd1000; divisor = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    lat = 4;
    dividend = 32'd50; divisor = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat++;
    checks++;
    if ({ready, quotient, remainder, overflow} !== {1'b0, pq, pr, pov}) begin
      failures++;
      $display("FAIL ignore_midcalc got rdy=%b q=%h r=%h ov=%b want rdy=0 q=%h r=%h ov=%b",
               ready, quotient, remainder, overflow, pq, pr, pov);
    end
    while (!ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL ignore_latency got %0d want 16", lat);
    end
    checks++;
    if ({quotient, remainder, overflow} !== {16'd333, 16'd1, 1'b0}) begin
      failures++;
      $display("FAIL ignore_result got q=%h r=%h ov=%b want q=014d r=0001 ov=0",
               quotient, remainder, overflow);
    end
  endtask

  task automatic test_reset_mid;
    dividend = 32'd5000; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({ready, quotient, remainder, overflow} !== {1'b1, 16'd0, 16'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid got rdy=%b q=%h r=%h ov=%b want rdy=1 q=0 r=0 ov=0",
               ready, quotient, remainder, overflow);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({ready, quotient, remainder, overflow} !== {1'b1, 16'd0, 16'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_quiet got rdy=%b q=%h r=%h ov=%b want rdy=1 q=0 r=0 ov=0",
               ready, quotient, remainder, overflow);
    end
    test_directed("after_reset", 32'd50, 16'd5, 16'd10, 16'd0, 1'b0, 16);
  endtask

  task automatic test_back_to_back;
    int lat;
    dividend = 32'd12345; divisor = 16'd100; start = 1'b1;
    @(posedge clk); #1;
    dividend = 32'h0003_0000; divisor = 16'd2;
    lat = 0;
    while (!ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({lat, quotient, remainder, overflow} !== {32'd16, 16'd123, 16'd45, 1'b0}) begin
      failures++;
      $display("FAIL b2b_first got lat=%0d q=%h r=%h ov=%b want lat=16 q=007b r=002d ov=0",
               lat, quotient, remainder, overflow);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept got rdy=%b want 0", ready);
    end
    lat = 0;
    while (!ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({lat, quotient, remainder, overflow} !== {32'd1, 16'hFFFF, 16'd0, 1'b1}) begin
      failures++;
      $display("FAIL b2b_second got lat=%0d q=%h r=%h ov=%b want lat=1 q=ffff r=0000 ov=1",
               lat, quotient, remainder, overflow);
    end
  endtask

  task automatic test_random;
    logic [31:0] dd;
    logic [15:0] dv, up, eq, er;
    logic        eov;
    int          elat, lat;
    for (int n = 0; n < 1000; n++) begin
      dv = 16'($urandom);
      if (dv == 16'd0) dv = 16'd1;
      up = 16'($urandom % dv);
      dd = {up, 16'($urandom)};
      case ($urandom_range(0, 7))
        0: dv = 16'd1;
        1: begin up = 16'($urandom_range(0, 16'hFFFE)); dd = {up, 16'($urandom)}; dv = up + 16'd1; end
        2: dd = 32'd0;
        3: dv = 16'd0;
        4: dd = $urandom;
        default: ;
      endcase
      model(dd, dv, eq, er, eov, elat);
      run_op(dd, dv, lat);
      checks++;
      if (lat !== elat) begin
        failures++;
        $display("FAIL rand_latency dd=%h dv=%h got %0d want %0d", dd, dv, lat, elat);
      end
      checks++;
      if ({quotient, remainder, overflow} !== {eq, er, eov}) begin
        failures++;
        $display("FAIL rand_result dd=%h dv=%h got q=%h r=%h ov=%b want q=%h r=%h ov=%b",
                 dd, dv, quotient, remainder, overflow, eq, er, eov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed("basic_100_7", 32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16);
    test_directed("max_quot", 32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'd0, 1'b0, 16);
    test_directed("ovf_upper", 32'h0001_0000, 16'd1, 16'hFFFF, 16'd0, 1'b1, 1);
    test_directed("ovf_div0", 32'h1234_5678, 16'd0, 16'hFFFF, 16'd0, 1'b1, 1);
    test_directed("zero_dividend", 32'd0, 16'd9, 16'd0, 16'd0, 1'b0, 16);
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, 16, divisor/quotient/remainder width; dividend is 2*WIDTH.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request a division; accepted only when ready=1.
REQ-005 Port: dividend  input  2*WIDTH  numerator, sampled on the accepting edge.
REQ-006 Port: divisor  input  WIDTH  denominator, sampled on the accepting edge.
REQ-007 Port: quotient  output  WIDTH  result quotient, registered.
REQ-008 Port: remainder  output  WIDTH  result remainder, registered.
REQ-009 Port: overflow  output  1  last result invalid: quotient does not fit WIDTH, or divisor=0.
REQ-010 Port: ready  output  1  high when idle and results valid; low while computing.

Function
REQ-011 Unsigned restoring division; quotient = dividend / divisor, remainder = dividend mod divisor.
REQ-012 States: IDLE, CALC, OVFL; reset state IDLE.
REQ-013 IDLE with start=1: capture operands; partial remainder = dividend[2W-1:W], quotient shift register = dividend[W-1:0], iteration count = 0; go to CALC, or to OVFL if dividend[2W-1:W] >= divisor.
REQ-014 Overflow test covers divisor=0 because any upper half >= 0.
REQ-015 CALC, one iteration per cycle: shift {partial remainder, quotient} left by 1 into a W+1-bit trial; subtract divisor; if result is non-negative, keep it and set quotient LSB=1, else restore and set LSB=0.
REQ-016 CALC lasts exactly WIDTH cycles; on the WIDTH-th iteration edge, load quotient/remainder outputs, overflow=0, ready=1, go to IDLE.
REQ-017 Latency: start accepted at edge N -> ready=1 and results valid after edge N+WIDTH (16 for default).
REQ-018 OVFL lasts one cycle; on its exit edge: quotient = all-ones, remainder = 0, overflow=1, ready=1, go to IDLE.
REQ-019 ready drops on the edge that accepts start, and stays low until completion.
REQ-020 start while ready=0 is ignored; operand changes during CALC/OVFL have no effect.
REQ-021 start held high continuously: a new operation is accepted on the first edge where ready=1.
REQ-022 quotient, remainder and overflow hold their last values in IDLE until the next completion.
REQ-023 Internal working registers are distinct from output registers; outputs do not change mid-computation.

Reset
REQ-024 reset=1 on an edge: state=IDLE, ready=1, quotient=0, remainder=0, overflow=0, counter and working registers cleared.
REQ-025 Reset mid-operation aborts it; no partial result appears on outputs.
REQ-026 reset has priority over start on the same edge.

Structure
REQ-027 Package seq_div_pkg holds the WIDTH default constant and the state enum typedef (IDLE, CALC, OVFL).
REQ-028 One sub-module is natural: div_step, combinational single restoring iteration (shift, trial subtract, select, quotient bit).
REQ-029 Iteration counter is $clog2(WIDTH)+1 bits wide; no multi-cycle or combinational divide operator.

Verification
REQ-030 dividend=100, divisor=7, pulse start -> ready low 16 cycles, then quotient=14, remainder=2, overflow=0.
REQ-031 dividend=32'hFFFE_0001, divisor=16'hFFFF -> quotient=16'hFFFF, remainder=0, overflow=0 after 16 cycles.
REQ-032 dividend=32'h0001_0000, divisor=1 -> after 1 cycle, overflow=1, quotient=16'hFFFF, remainder=0; divisor=0 with any dividend gives the same result.
REQ-033 start re-pulsed with new operands at cycle 5 of CALC -> ignored; the first result is unchanged and ready stays low until cycle 16.
REQ-034 reset asserted at cycle 8 of CALC -> next cycle ready=1 and outputs=0; a following 50/5 request gives quotient=10, remainder=0.
REQ-035 Random 1000 operand pairs against a reference model, including divisor=1, divisor=dividend upper half+1, dividend=0.
